// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of mem_port_arbiter.
// slave is the arbiter's view; master is the requesters plus the memory instance.
interface mem_port_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned HEIGHT = 1024
);
  localparam int unsigned AW  = $clog2(HEIGHT);
  localparam int unsigned IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]       rd_req_valid;
  logic [N_REQ*AW-1:0]    rd_req_addr;
  logic [N_REQ-1:0]       rd_req_ready;
  logic                   rd_rsp_valid;
  logic [IDW-1:0]         rd_rsp_id;
  logic [WIDTH-1:0]       rd_rsp_data;

  logic [N_REQ-1:0]       wr_req_valid;
  logic [N_REQ*AW-1:0]    wr_req_addr;
  logic [N_REQ*WIDTH-1:0] wr_req_data;
  logic [N_REQ-1:0]       wr_req_ready;

  logic [AW-1:0]          mem_read_addr;
  logic                   mem_read_en;
  logic [WIDTH-1:0]       mem_qout;
  logic [AW-1:0]          mem_write_addr;
  logic                   mem_write_en;
  logic [WIDTH-1:0]       mem_din;

  modport slave (
    input  rd_req_valid, rd_req_addr,
    output rd_req_ready, rd_rsp_valid, rd_rsp_id, rd_rsp_data,
    input  wr_req_valid, wr_req_addr, wr_req_data,
    output wr_req_ready,
    output mem_read_addr, mem_read_en,
    input  mem_qout,
    output mem_write_addr, mem_write_en, mem_din
  );

  modport master (
    output rd_req_valid, rd_req_addr,
    input  rd_req_ready, rd_rsp_valid, rd_rsp_id, rd_rsp_data,
    output wr_req_valid, wr_req_addr, wr_req_data,
    input  wr_req_ready,
    input  mem_read_addr, mem_read_en,
    output mem_qout,
    input  mem_write_addr, mem_write_en, mem_din
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one pseudo-2-port memory among N_REQ requesters.
// Read and write ports arbitrate independently; read data is registered one cycle after grant.
module mem_port_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned HEIGHT = 1024
) (
  input  logic              clk,
  input  logic              arst,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned AW  = $clog2(HEIGHT);
  localparam int unsigned IDW = $clog2(N_REQ);

  typedef logic [IDW-1:0] idx_t;

  // Returns {found, index}: first set valid bit at or after ptr, wrapping mod N_REQ.
  function automatic logic [IDW:0] rr_pick(input logic [N_REQ-1:0] valid, input idx_t ptr);
    logic [IDW:0] res;
    int unsigned  cand;
    res = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = (32'(ptr) + k) % N_REQ;
      if (!res[IDW] && valid[idx_t'(cand)]) res = {1'b1, idx_t'(cand)};
    end
    return res;
  endfunction

  function automatic idx_t ptr_next(input idx_t cur);
    return (cur == idx_t'(N_REQ - 1)) ? '0 : cur + idx_t'(1);
  endfunction

  logic [AW-1:0]    rd_addr_a [N_REQ];
  logic [AW-1:0]    wr_addr_a [N_REQ];
  logic [WIDTH-1:0] wr_data_a [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign rd_addr_a[g] = bus.rd_req_addr[g*AW +: AW];
    assign wr_addr_a[g] = bus.wr_req_addr[g*AW +: AW];
    assign wr_data_a[g] = bus.wr_req_data[g*WIDTH +: WIDTH];
  end

  idx_t             rd_ptr_q, rd_ptr_d;
  idx_t             wr_ptr_q, wr_ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  idx_t             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic [IDW:0] rd_pick, wr_pick;
  logic         rd_gnt, wr_gnt;
  idx_t         rd_idx, wr_idx;

  assign rd_pick = rr_pick(bus.rd_req_valid, rd_ptr_q);
  assign wr_pick = rr_pick(bus.wr_req_valid, wr_ptr_q);
  // Grants are suppressed combinationally while reset is held, independent of the valids.
  assign rd_gnt  = rd_pick[IDW] && !arst;
  assign wr_gnt  = wr_pick[IDW] && !arst;
  assign rd_idx  = rd_pick[IDW-1:0];
  assign wr_idx  = wr_pick[IDW-1:0];

  always_comb begin
    bus.rd_req_ready  = '0;
    bus.mem_read_en   = 1'b0;
    bus.mem_read_addr = '0;
    rd_ptr_d          = rd_ptr_q;
    rsp_valid_d       = 1'b0;
    rsp_id_d          = rsp_id_q;
    rsp_data_d        = rsp_data_q;
    if (rd_gnt) begin
      bus.rd_req_ready[rd_idx] = 1'b1;
      bus.mem_read_en          = 1'b1;
      bus.mem_read_addr        = rd_addr_a[rd_idx];
      rd_ptr_d                 = ptr_next(rd_idx);
      rsp_valid_d              = 1'b1;
      rsp_id_d                 = rd_idx;
      rsp_data_d               = bus.mem_qout;
    end
  end

  always_comb begin
    bus.wr_req_ready   = '0;
    bus.mem_write_en   = 1'b0;
    bus.mem_write_addr = '0;
    bus.mem_din        = '0;
    wr_ptr_d           = wr_ptr_q;
    if (wr_gnt) begin
      bus.wr_req_ready[wr_idx] = 1'b1;
      bus.mem_write_en         = 1'b1;
      bus.mem_write_addr       = wr_addr_a[wr_idx];
      bus.mem_din              = wr_data_a[wr_idx];
      wr_ptr_d                 = ptr_next(wr_idx);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.rd_rsp_valid = rsp_valid_q;
  assign bus.rd_rsp_id    = rsp_id_q;
  assign bus.rd_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural memory, round-robin reference model with a
// response scoreboard, plus scenario tasks with fixed expected values.
module tb_mem_port_arbiter;
  localparam int N_REQ  = 4;
  localparam int WIDTH  = 16;
  localparam int HEIGHT = 1024;
  localparam int AW     = 10;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) bus ();

  mem_port_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  // Requester-side stimulus.
  logic [N_REQ-1:0] rq_rv, rq_wv;
  logic [AW-1:0]    rq_ra [N_REQ];
  logic [AW-1:0]    rq_wa [N_REQ];
  logic [WIDTH-1:0] rq_wd [N_REQ];

  assign bus.rd_req_valid = rq_rv;
  assign bus.wr_req_valid = rq_wv;
  for (genvar g = 0; g < N_REQ; g++) begin : g_pack
    assign bus.rd_req_addr[g*AW +: AW]       = rq_ra[g];
    assign bus.wr_req_addr[g*AW +: AW]       = rq_wa[g];
    assign bus.wr_req_data[g*WIDTH +: WIDTH] = rq_wd[g];
  end

  // Memory contents before any write: a fixed address-derived pattern.
  function automatic logic [WIDTH-1:0] init_pat(input logic [AW-1:0] a);
    return {a[5:0], a} ^ 16'h3C5A;
  endfunction

  // Memory instance model: zero-latency read, write commits at the rising edge.
  logic [WIDTH-1:0] mem_arr [HEIGHT];
  bit               mem_set [HEIGHT];
  assign bus.mem_qout = mem_set[bus.mem_read_addr] ? mem_arr[bus.mem_read_addr]
                                                   : init_pat(bus.mem_read_addr);
  always @(posedge clk) begin
    if (bus.mem_write_en) begin
      mem_arr[bus.mem_write_addr] <= bus.mem_din;
      mem_set[bus.mem_write_addr] <= 1'b1;
    end
  end

  // Reference model state and scoreboard.
  typedef struct {
    int               due;
    logic [1:0]       id;
    logic [WIDTH-1:0] data;
  } rsp_t;

  rsp_t             sb [$];
  logic [WIDTH-1:0] ref_arr [HEIGHT];
  bit               ref_set [HEIGHT];
  int               m_rd_ptr = 0;
  int               m_wr_ptr = 0;
  int               cyc = 0;
  int               n_cmp = 0;
  int               n_err = 0;

  function automatic int rr(input logic [N_REQ-1:0] v, input int ptr);
    int j;
    for (int k = 0; k < N_REQ; k++) begin
      j = (ptr + k) % N_REQ;
      if (v[j[1:0]]) return j;
    end
    return -1;
  endfunction

  // Per-cycle checker: grants and memory port drive against the model, responses against
  // the scoreboard, then the model commits the cycle.
  task automatic monitor();
    int               e_rd, e_wr;
    logic [1:0]       ri, wi;
    logic [N_REQ-1:0] e_rg, e_wg;
    logic [AW-1:0]    ra, wa;
    logic [WIDTH-1:0] wd, rdat;
    rsp_t             exp_r;
    forever begin
      @(negedge clk);
      cyc++;
      if (arst) begin
        n_cmp++;
        if (bus.rd_req_ready !== 4'b0 || bus.wr_req_ready !== 4'b0 || bus.mem_read_en !== 1'b0 ||
            bus.mem_write_en !== 1'b0 || bus.rd_rsp_valid !== 1'b0) begin
          n_err++;
          $display("FAIL reset_quiet: rd_rdy=%b wr_rdy=%b ren=%b wen=%b rsp_v=%b, required all 0",
                   bus.rd_req_ready, bus.wr_req_ready, bus.mem_read_en, bus.mem_write_en,
                   bus.rd_rsp_valid);
        end
        m_rd_ptr = 0;
        m_wr_ptr = 0;
        sb.delete();
      end else begin
        e_rd = rr(rq_rv, m_rd_ptr);
        e_wr = rr(rq_wv, m_wr_ptr);
        ri   = 2'(e_rd);
        wi   = 2'(e_wr);
        e_rg = (e_rd >= 0) ? (4'b0001 << ri) : 4'b0000;
        e_wg = (e_wr >= 0) ? (4'b0001 << wi) : 4'b0000;
        ra   = (e_rd >= 0) ? rq_ra[ri] : '0;
        wa   = (e_wr >= 0) ? rq_wa[wi] : '0;
        wd   = (e_wr >= 0) ? rq_wd[wi] : '0;

        n_cmp++;
        if (bus.rd_req_ready !== e_rg) begin
          n_err++;
          $display("FAIL rd_grant: got %b, required %b (cycle %0d)", bus.rd_req_ready, e_rg, cyc);
        end
        n_cmp++;
        if (bus.wr_req_ready !== e_wg) begin
          n_err++;
          $display("FAIL wr_grant: got %b, required %b (cycle %0d)", bus.wr_req_ready, e_wg, cyc);
        end
        n_cmp++;
        if ({bus.mem_read_en, bus.mem_read_addr} !== {e_rd >= 0, ra}) begin
          n_err++;
          $display("FAIL rd_port: en/addr got %b/%0d, required %b/%0d", bus.mem_read_en,
                   bus.mem_read_addr, e_rd >= 0, ra);
        end
        n_cmp++;
        if ({bus.mem_write_en, bus.mem_write_addr, bus.mem_din} !== {e_wr >= 0, wa, wd}) begin
          n_err++;
          $display("FAIL wr_port: en/addr/din got %b/%0d/%h, required %b/%0d/%h", bus.mem_write_en,
                   bus.mem_write_addr, bus.mem_din, e_wr >= 0, wa, wd);
        end

        n_cmp++;
        if (sb.size() > 0 && sb[0].due == cyc) begin
          exp_r = sb.pop_front();
          if (bus.rd_rsp_valid !== 1'b1 || bus.rd_rsp_id !== exp_r.id ||
              bus.rd_rsp_data !== exp_r.data) begin
            n_err++;
            $display("FAIL rd_rsp: v/id/data got %b/%0d/%h, required 1/%0d/%h", bus.rd_rsp_valid,
                     bus.rd_rsp_id, bus.rd_rsp_data, exp_r.id, exp_r.data);
          end
        end else if (bus.rd_rsp_valid !== 1'b0) begin
          n_err++;
          $display("FAIL rd_rsp_idle: valid got %b, required 0 (cycle %0d)", bus.rd_rsp_valid, cyc);
        end

        // Read samples memory before this cycle's write lands.
        if (e_rd >= 0) begin
          rdat = ref_set[ra] ? ref_arr[ra] : init_pat(ra);
          sb.push_back('{due: cyc + 1, id: ri, data: rdat});
          m_rd_ptr = (e_rd + 1) % N_REQ;
        end
        if (e_wr >= 0) begin
          ref_arr[wa] = wd;
          ref_set[wa] = 1'b1;
          m_wr_ptr    = (e_wr + 1) % N_REQ;
        end
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rq_rv = '0;
    rq_wv = '0;
    arst  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    arst = 1'b0;
  endtask

  task automatic test_reset();
    arst  = 1'b1;
    rq_rv = '1;
    rq_wv = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.rd_req_ready !== 4'b0 || bus.wr_req_ready !== 4'b0) begin
      n_err++;
      $display("FAIL reset_ready: rd=%b wr=%b, required 0000/0000", bus.rd_req_ready, bus.wr_req_ready);
    end
    n_cmp++;
    if (bus.mem_read_en !== 1'b0 || bus.mem_write_en !== 1'b0) begin
      n_err++;
      $display("FAIL reset_en: ren=%b wen=%b, required 0/0", bus.mem_read_en, bus.mem_write_en);
    end
    n_cmp++;
    if ({bus.rd_rsp_valid, bus.rd_rsp_id, bus.rd_rsp_data} !== 19'b0) begin
      n_err++;
      $display("FAIL reset_rsp: v/id/data=%b/%0d/%h, required 0/0/0000", bus.rd_rsp_valid,
               bus.rd_rsp_id, bus.rd_rsp_data);
    end
    @(posedge clk);
    #1;
    arst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.rd_req_ready !== 4'b0001 || bus.wr_req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL release_grant: rd=%b wr=%b, required 0001/0001", bus.rd_req_ready, bus.wr_req_ready);
    end
    next_cycle();
    rq_rv = '0;
    rq_wv = '0;
  endtask

  task automatic test_fairness();
    logic [AW-1:0] a;
    apply_reset();
    for (int i = 0; i < N_REQ; i++) begin
      rq_ra[i] = 10'(300 + i);
      rq_wa[i] = 10'(400 + i);
      rq_wd[i] = 16'(16'hF000 + i);
    end
    rq_rv = '1;
    rq_wv = '1;
    for (int k = 0; k <= 8; k++) begin
      if (k == 8) begin
        rq_rv = '0;
        rq_wv = '0;
      end
      @(negedge clk);
      if (k < 8) begin
        n_cmp++;
        if (bus.rd_req_ready !== (4'b0001 << (k % 4)) || bus.wr_req_ready !== (4'b0001 << (k % 4))) begin
          n_err++;
          $display("FAIL rr_order: step %0d rd=%b wr=%b, required %b", k, bus.rd_req_ready,
                   bus.wr_req_ready, 4'b0001 << (k % 4));
        end
      end
      if (k > 0) begin
        a = 10'(300 + (k - 1) % 4);
        n_cmp++;
        if (bus.rd_rsp_valid !== 1'b1 || bus.rd_rsp_id !== 2'((k - 1) % 4) ||
            bus.rd_rsp_data !== init_pat(a)) begin
          n_err++;
          $display("FAIL rr_rsp: step %0d v/id/data=%b/%0d/%h, required 1/%0d/%h", k,
                   bus.rd_rsp_valid, bus.rd_rsp_id, bus.rd_rsp_data, (k - 1) % 4, init_pat(a));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_pointer_skip();
    int seq [3] = '{3, 0, 3};
    rq_rv = 4'b0001;
    @(negedge clk);
    n_cmp++;
    if (bus.rd_req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL skip_setup: rd=%b, required 0001", bus.rd_req_ready);
    end
    next_cycle();
    rq_rv = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.rd_req_ready !== (4'b0001 << seq[k])) begin
        n_err++;
        $display("FAIL skip_grant: step %0d rd=%b, required %b", k, bus.rd_req_ready,
                 4'b0001 << seq[k]);
      end
      next_cycle();
    end
    rq_rv = '0;
    next_cycle();
  endtask

  task automatic test_write_then_read();
    rq_wv    = 4'b0100;
    rq_wa[2] = 10'd5;
    rq_wd[2] = 16'hBEEF;
    @(negedge clk);
    n_cmp++;
    if (bus.wr_req_ready !== 4'b0100 || bus.mem_write_addr !== 10'd5 || bus.mem_din !== 16'hBEEF) begin
      n_err++;
      $display("FAIL wtr_write: rdy/addr/din=%b/%0d/%h, required 0100/5/beef", bus.wr_req_ready,
               bus.mem_write_addr, bus.mem_din);
    end
    next_cycle();
    rq_wv    = '0;
    rq_rv    = 4'b0010;
    rq_ra[1] = 10'd5;
    next_cycle();
    rq_rv = '0;
    @(negedge clk);
    n_cmp++;
    if (bus.rd_rsp_valid !== 1'b1 || bus.rd_rsp_id !== 2'd1 || bus.rd_rsp_data !== 16'hBEEF) begin
      n_err++;
      $display("FAIL wtr_read: v/id/data=%b/%0d/%h, required 1/1/beef", bus.rd_rsp_valid,
               bus.rd_rsp_id, bus.rd_rsp_data);
    end
    next_cycle();
  endtask

  task automatic test_same_cycle();
    rq_wv    = 4'b0001;
    rq_wa[0] = 10'd7;
    rq_wd[0] = 16'h1234;
    next_cycle();
    rq_wd[0] = 16'hAAAA;
    rq_rv    = 4'b1000;
    rq_ra[3] = 10'd7;
    @(negedge clk);
    n_cmp++;
    if (bus.rd_req_ready !== 4'b1000 || bus.wr_req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL same_grant: rd=%b wr=%b, required 1000/0001", bus.rd_req_ready, bus.wr_req_ready);
    end
    next_cycle();
    rq_wv    = '0;
    rq_rv    = 4'b0100;
    rq_ra[2] = 10'd7;
    @(negedge clk);
    n_cmp++;
    if (bus.rd_rsp_valid !== 1'b1 || bus.rd_rsp_id !== 2'd3 || bus.rd_rsp_data !== 16'h1234) begin
      n_err++;
      $display("FAIL same_old: v/id/data=%b/%0d/%h, required 1/3/1234", bus.rd_rsp_valid,
               bus.rd_rsp_id, bus.rd_rsp_data);
    end
    next_cycle();
    rq_rv = '0;
    @(negedge clk);
    n_cmp++;
    if (bus.rd_rsp_valid !== 1'b1 || bus.rd_rsp_id !== 2'd2 || bus.rd_rsp_data !== 16'hAAAA) begin
      n_err++;
      $display("FAIL same_new: v/id/data=%b/%0d/%h, required 1/2/aaaa", bus.rd_rsp_valid,
               bus.rd_rsp_id, bus.rd_rsp_data);
    end
    next_cycle();
  endtask

  task automatic test_reset_midop();
    rq_rv    = 4'b0100;
    rq_ra[2] = 10'd9;
    #1;
    n_cmp++;
    if (bus.rd_req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL midop_pre: rd=%b, required 0100", bus.rd_req_ready);
    end
    arst = 1'b1;
    #1;
    n_cmp++;
    if (bus.rd_req_ready !== 4'b0 || bus.mem_read_en !== 1'b0) begin
      n_err++;
      $display("FAIL midop_gate: rd=%b ren=%b, required 0000/0", bus.rd_req_ready, bus.mem_read_en);
    end
    next_cycle();
    n_cmp++;
    if (bus.rd_rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midop_rsp: valid=%b, required 0", bus.rd_rsp_valid);
    end
    arst  = 1'b0;
    rq_rv = '1;
    rq_wv = '1;
    @(negedge clk);
    n_cmp++;
    if (bus.rd_req_ready !== 4'b0001 || bus.wr_req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL midop_ptr: rd=%b wr=%b, required 0001/0001", bus.rd_req_ready, bus.wr_req_ready);
    end
    next_cycle();
    rq_rv = '0;
    rq_wv = '0;
    @(negedge clk);
    n_cmp++;
    if (bus.rd_rsp_valid !== 1'b1 || bus.rd_rsp_id !== 2'd0) begin
      n_err++;
      $display("FAIL midop_after: v/id=%b/%0d, required 1/0", bus.rd_rsp_valid, bus.rd_rsp_id);
    end
    next_cycle();
  endtask

  initial begin
    arst  = 1'b1;
    rq_rv = '0;
    rq_wv = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rq_ra[i] = 10'(100 + i);
      rq_wa[i] = 10'(200 + i);
      rq_wd[i] = 16'(16'hD000 + i);
    end
    fork
      monitor();
    join_none
    test_reset();
    test_fairness();
    test_pointer_skip();
    test_write_then_read();
    test_same_cycle();
    test_reset_midop();
    repeat (3) next_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares one pseudo-2-port `memory` instance between N_REQ requesters (e.g. PE-array load/store units and the host loader). Read and write ports are arbitrated independently, each with its own rotating priority pointer. Granted reads drive the memory's zero-latency read port and return data through a registered response one cycle later. Granted writes drive the write port and commit on the same rising edge. The block sits between the compute controllers and a `memory` instance, whether that instance is used as external or on-chip memory.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 16, data width; must match the memory instance
- HEIGHT, 1024, memory depth; AW = $clog2(HEIGHT)
- clk  in  1  sole clock, rising-edge
- arst  in  1  reset, asynchronous and active-high
- rd_req_valid  in  N_REQ  per-requester read request
- rd_req_addr  in  N_REQ*AW  read addresses; requester i at bits [i*AW +: AW]
- rd_req_ready  out  N_REQ  one-hot read grant, combinational
- rd_rsp_valid  out  1  read data valid, registered
- rd_rsp_id  out  $clog2(N_REQ)  index of the requester owning rd_rsp_data
- rd_rsp_data  out  WIDTH  registered read data
- wr_req_valid  in  N_REQ  per-requester write request
- wr_req_addr  in  N_REQ*AW  write addresses, same packing as rd_req_addr
- wr_req_data  in  N_REQ*WIDTH  write data; requester i at bits [i*WIDTH +: WIDTH]
- wr_req_ready  out  N_REQ  one-hot write grant, combinational
- mem_read_addr  out  AW  to memory read_addr
- mem_read_en  out  1  to memory read_en
- mem_qout  in  WIDTH  from memory qout
- mem_write_addr  out  AW  to memory write_addr
- mem_write_en  out  1  to memory write_en
- mem_din  out  WIDTH  to memory din

## Operation
- **Transfer rule:** a transfer happens in cycle c when valid[i] and ready[i] are both high. Requesters hold valid, addr and data stable until ready. Ready never depends on the requester's own ready.
- **Read arbitration:**
  - Among set rd_req_valid bits, grant the first index at or after rd_ptr, searching upward mod N_REQ.
  - At most one rd_req_ready bit is high.
  - No valid bit set → no grant.
- **Read pointer update:** on a granted cycle, rd_ptr <= granted index + 1 mod N_REQ. Otherwise rd_ptr holds.
- **Write arbitration:** identical, using its own wr_ptr.
- **Read port drive:**
  - mem_read_en = 1 only on a read grant.
  - mem_read_addr = the granted address.
  - With no grant, mem_read_addr = 0 and mem_read_en = 0. This keeps read energy to granted accesses only.
- **Write port drive:**
  - mem_write_en = 1 only on a write grant.
  - mem_write_addr and mem_din = the granted address and data.
  - With no grant, both are 0.
- **Read response capture:** on a read grant, capture at the edge: rd_rsp_data <= mem_qout, rd_rsp_id <= granted index, rd_rsp_valid <= 1.
- **Idle read response:** on a cycle with no read grant, rd_rsp_valid <= 0, and rd_rsp_data and rd_rsp_id hold.
- **No backpressure:** responses have no backpressure. A requester must accept rd_rsp_valid whenever it matches rd_rsp_id.
- **Same-address read and write in one cycle:** the read returns the OLD memory contents (the memory writes at the edge). The new value is visible to a read granted in cycle c+1 or later.
- **Read and write of different requesters** proceed in the same cycle without interaction.
- **Reset state:** while arst = 1:
  - rd_ptr = wr_ptr = 0.
  - rd_rsp_valid = 0, rd_rsp_id = 0, rd_rsp_data = 0.
  - All ready outputs and mem enables are forced 0, regardless of valids.
- **Reset mid-operation:** a request granted in the cycle arst rises produces no response. Whether the memory write commits is undefined; the bench must not check it.

## Timing
- **Grant latency:** 0 cycles. Ready is combinational from valid and the pointer.
- **Write latency:** data is stored at the rising edge that ends the grant cycle.
- **Read latency:** 1 cycle from grant to rd_rsp_valid.
- **Throughput:** one read and one write per cycle in total, across all requesters.
- **Fairness:** with all N_REQ valid continuously, each requester is granted exactly once every N_REQ cycles per port. Maximum wait for a held request is N_REQ-1 cycles.
- **Reset release:** arst falls asynchronously. Arbitration begins in the first cycle after release, starting with priority at requester 0.

## Test plan
- **Reset:**
  - Stimulus: hold arst high with all valids = 1; then release.
  - Response: all readys = 0, mem_read_en = mem_write_en = 0, and rd_rsp_valid = 0 during reset. Requester 0 is granted on both ports in the first cycle after release.
- **Round-robin fairness:**
  - Stimulus: N_REQ = 4, all rd_req_valid held high for 8 cycles.
  - Response: grants 0,1,2,3,0,1,2,3. rd_rsp_id follows one cycle later with matching data.
- **Pointer skip:**
  - Stimulus: rd_ptr = 1, only valids 0 and 3 set.
  - Response: grant 3, then 0, then 3.
- **Write-then-read:**
  - Stimulus: requester 2 writes 0xBEEF to address 5 in cycle c. Requester 1 reads address 5 in cycle c+1.
  - Response: rd_rsp_data = 0xBEEF and rd_rsp_id = 1 in cycle c+2.
- **Same-cycle read and write:**
  - Stimulus: address 7 holds 0x1234. In the same cycle, write 0xAAAA to address 7 and read address 7.
  - Response: the read returns 0x1234. The next read of address 7 returns 0xAAAA.
- **Reset mid-operation:**
  - Stimulus: assert arst in a read-grant cycle.
  - Response: rd_rsp_valid stays 0. Both pointers return to 0.
